mram_bus_ctrl: RTL and testbench

Bus-timing engine between the serial-to-parallel front end and the external 16-bit asynchronous MRAM (20-bit address, active-low CE/WE/OE/LB/UB).
Accepts one parallel read or write request through a valid/ready handshake. Sequences the MRAM strobes with programmable cycle counts and returns read data through a single-cycle response strobe.
All MRAM pins are driven from registers, so there is no combinational path from request inputs to the pins.

---
 rtl/mram_bus_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_mram_bus_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mram_bus_ctrl.sv
// Purpose : bus-timing engine that turns one parallel read/write request into
//           registered, programmable-length strobe sequences on a 16-bit async MRAM.
// Latency : write occupies SETUP+WR_PULSE+RECOVERY+1 edges, read SETUP+RD_ACCESS+RECOVERY+1;
//           read data returns as a one-cycle rsp_valid pulse on leaving READ.
// Backpressure: req_ready drops on accept and rises on return to IDLE; the response
//           channel has none, so the consumer must take rsp_valid when it pulses.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake; req_we, req_addr, req_wdata, req_be payload
//   rsp_valid/rsp_rdata      read response pulse and data (disabled bytes read as 0x00)
//   busy                     high whenever the engine is not IDLE
//   mram_*                   MRAM pins, all driven straight from registers;
//                            mram_dq_oe enables the IOBUF instantiated at the top level

module mram_bus_ctrl #(
    parameter int ADDR_W        = 20,
    parameter int DATA_W        = 16,
    parameter int SETUP_CYC     = 1,
    parameter int WR_PULSE_CYC  = 3,
    parameter int RD_ACCESS_CYC = 4,
    parameter int RECOVERY_CYC  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mram_addr,
    output logic [DATA_W-1:0] mram_dq_o,
    output logic              mram_dq_oe,
    input  logic [DATA_W-1:0] mram_dq_i,
    output logic              mram_ce_n,
    output logic              mram_we_n,
    output logic              mram_oe_n,
    output logic              mram_lb_n,
    output logic              mram_ub_n
);

    localparam int HALF    = DATA_W / 2;
    localparam int MAX_SW  = (SETUP_CYC > WR_PULSE_CYC) ? SETUP_CYC : WR_PULSE_CYC;
    localparam int MAX_RR  = (RD_ACCESS_CYC > RECOVERY_CYC) ? RD_ACCESS_CYC : RECOVERY_CYC;
    localparam int MAX_CYC = (MAX_SW > MAX_RR) ? MAX_SW : MAX_RR;
    // The counter only ever holds (length - 1), so MAX_CYC-1 must fit.
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] WR_LD    = CNT_W'(WR_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] RD_LD    = CNT_W'(RD_ACCESS_CYC - 1);
    localparam logic [CNT_W-1:0] REC_LD   = CNT_W'(RECOVERY_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WRITE,
        ST_READ,
        ST_RECOVER
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_we;
    logic [1:0]         r_be;
    logic               r_req_ready;
    logic               r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_rdata;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_dq_o;
    logic               r_dq_oe;
    logic               r_ce_n;
    logic               r_we_n;
    logic               r_oe_n;
    logic               r_lb_n;
    logic               r_ub_n;

    logic               w_accept;
    logic               w_cnt_done;
    logic [DATA_W-1:0]  w_rd_masked;

    assign w_accept    = req_valid && r_req_ready;
    assign w_cnt_done  = (r_cnt == '0);
    // Bytes that were not enabled are not driven by the MRAM, so force them to zero.
    assign w_rd_masked = {{HALF{r_be[1]}}, {HALF{r_be[0]}}} & mram_dq_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_be        <= 2'b00;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_addr      <= '0;
            r_dq_o      <= '0;
            r_dq_oe     <= 1'b0;
            r_ce_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_lb_n      <= 1'b1;
            r_ub_n      <= 1'b1;
        end else begin
            // Response is a single-cycle pulse unless re-armed below.
            r_rsp_valid <= 1'b0;

            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_we        <= req_we;
                        r_be        <= req_be;
                        if (req_be != 2'b00) begin
                            r_state <= ST_SETUP;
                            r_cnt   <= SETUP_LD;
                            r_addr  <= req_addr;
                            r_ce_n  <= 1'b0;
                            r_lb_n  <= !req_be[0];
                            r_ub_n  <= !req_be[1];
                            if (req_we) begin
                                r_dq_o  <= req_wdata;
                                r_dq_oe <= 1'b1;
                            end
                        end else begin
                            // No byte selected: skip the bus cycle entirely and spend a
                            // single RECOVER cycle so req_ready returns one cycle later.
                            r_state <= ST_RECOVER;
                            r_cnt   <= '0;
                            if (!req_we) begin
                                r_rsp_valid <= 1'b1;
                                r_rsp_rdata <= '0;
                            end
                        end
                    end
                end

                ST_SETUP: begin
                    if (w_cnt_done) begin
                        if (r_we) begin
                            r_state <= ST_WRITE;
                            r_cnt   <= WR_LD;
                            r_we_n  <= 1'b0;
                        end else begin
                            r_state <= ST_READ;
                            r_cnt   <= RD_LD;
                            r_oe_n  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                ST_WRITE: begin
                    if (w_cnt_done) begin
                        // Strobes release; address, data and dq_oe stay put for hold time.
                        r_state <= ST_RECOVER;
                        r_cnt   <= REC_LD;
                        r_ce_n  <= 1'b1;
                        r_we_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_lb_n  <= 1'b1;
                        r_ub_n  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                ST_READ: begin
                    if (w_cnt_done) begin
                        // Sample while OE_n is still low on this edge.
                        r_rsp_rdata <= w_rd_masked;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RECOVER;
                        r_cnt       <= REC_LD;
                        r_ce_n      <= 1'b1;
                        r_we_n      <= 1'b1;
                        r_oe_n      <= 1'b1;
                        r_lb_n      <= 1'b1;
                        r_ub_n      <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                ST_RECOVER: begin
                    if (w_cnt_done) begin
                        r_state     <= ST_IDLE;
                        r_dq_oe     <= 1'b0;
                        r_req_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= '0;
                    r_req_ready <= 1'b1;
                    r_dq_oe     <= 1'b0;
                    r_ce_n      <= 1'b1;
                    r_we_n      <= 1'b1;
                    r_oe_n      <= 1'b1;
                    r_lb_n      <= 1'b1;
                    r_ub_n      <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign busy       = (r_state != ST_IDLE);
    assign mram_addr  = r_addr;
    assign mram_dq_o  = r_dq_o;
    assign mram_dq_oe = r_dq_oe;
    assign mram_ce_n  = r_ce_n;
    assign mram_we_n  = r_we_n;
    assign mram_oe_n  = r_oe_n;
    assign mram_lb_n  = r_lb_n;
    assign mram_ub_n  = r_ub_n;

endmodule

// File: tb/tb_mram_bus_ctrl.sv
// Bench for mram_bus_ctrl: directed cases followed by random requests, scored against
// a word-level memory reference and a timing budget computed from the cycle parameters.
// Includes a behavioural async MRAM driving mram_dq_i and a per-cycle strobe checker.

module tb_mram_bus_ctrl;

    localparam int SETUP = 1;
    localparam int WRP   = 3;
    localparam int RDA   = 4;
    localparam int REC   = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [19:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_be = 2'b00;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        busy;
    logic [19:0] mram_addr;
    logic [15:0] mram_dq_o;
    logic        mram_dq_oe;
    logic [15:0] mram_dq_i = 16'hDEAD;
    logic        mram_ce_n, mram_we_n, mram_oe_n, mram_lb_n, mram_ub_n;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mram_bus_ctrl #(
        .ADDR_W(20), .DATA_W(16), .SETUP_CYC(SETUP), .WR_PULSE_CYC(WRP),
        .RD_ACCESS_CYC(RDA), .RECOVERY_CYC(REC)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .mram_addr(mram_addr), .mram_dq_o(mram_dq_o), .mram_dq_oe(mram_dq_oe),
        .mram_dq_i(mram_dq_i), .mram_ce_n(mram_ce_n), .mram_we_n(mram_we_n),
        .mram_oe_n(mram_oe_n), .mram_lb_n(mram_lb_n), .mram_ub_n(mram_ub_n)
    );

    // Device contents (written from the pins) and reference contents (written from requests).
    logic [15:0] dev_mem [logic [19:0]];
    logic [15:0] ref_mem [logic [19:0]];

    function automatic logic [15:0] dflt(input logic [19:0] a);
        return a[15:0] ^ 16'hA5A5;
    endfunction

    function automatic logic [15:0] dev_rd(input logic [19:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : dflt(a);
    endfunction

    function automatic logic [15:0] ref_rd(input logic [19:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                          input logic en_lo, input logic en_hi);
        return {en_hi ? nw[15:8] : old[15:8], en_lo ? nw[7:0] : old[7:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Async MRAM: stores enabled bytes while CE_n and WE_n are low; drives data half a
    // cycle after OE_n is seen low, otherwise a recognisable junk pattern.
    initial forever begin
        @(posedge clk);
        if (!rst && !mram_ce_n && !mram_we_n)
            dev_mem[mram_addr] = merge(dev_rd(mram_addr), mram_dq_o, !mram_lb_n, !mram_ub_n);
    end

    initial forever begin
        @(negedge clk);
        mram_dq_i = (!mram_ce_n && !mram_oe_n) ? dev_rd(mram_addr) : 16'hDEAD;
    end

    // Strobe invariants, every cycle out of reset.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            check("inv_we_oe_overlap", 32'(!(!mram_we_n && !mram_oe_n)), 32'd1);
            check("inv_strobe_no_ce",  32'(!(mram_ce_n && (!mram_we_n || !mram_oe_n))), 32'd1);
            check("inv_dqoe_in_read",  32'(!(!mram_oe_n && mram_dq_oe)), 32'd1);
            check("inv_we_without_dq", 32'(!(!mram_we_n && !mram_dq_oe)), 32'd1);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // One request, observed cycle by cycle from the accept edge until req_ready returns.
    task automatic run_req(input logic we, input logic [19:0] a, input logic [15:0] d,
                           input logic [1:0] be);
        int i, ce_cnt, ce_first, we_cnt, we_first, oe_cnt, oe_first;
        int dqoe_cnt, rsp_cnt, rsp_idx, bad_pin, busy_lo;
        logic [15:0] rdata, exp_rd;
        exp_rd = ref_rd(a) & {{8{be[1]}}, {8{be[0]}}};
        ce_cnt = 0; ce_first = -1; we_cnt = 0; we_first = -1; oe_cnt = 0; oe_first = -1;
        dqoe_cnt = 0; rsp_cnt = 0; rsp_idx = -1; bad_pin = 0; busy_lo = 0; rdata = 16'hxxxx;

        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
        i = 0;
        while (!req_ready && i < 40) begin @(negedge clk); i++; end
        check("ready_before_accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        i = 0;
        do begin
            @(negedge clk);
            if (i == 0) begin
                // Scramble the request inputs: none of this may reach the pins.
                req_valid = 1'b0; req_we = ~we; req_addr = 20'($urandom);
                req_wdata = 16'($urandom); req_be = ~be;
            end
            if (!busy) busy_lo++;
            if (!mram_ce_n) begin
                ce_cnt++;
                if (ce_first < 0) ce_first = i;
                if (mram_addr !== a) bad_pin++;
                if (mram_lb_n !== !be[0] || mram_ub_n !== !be[1]) bad_pin++;
            end
            if (!mram_we_n) begin we_cnt++; if (we_first < 0) we_first = i; end
            if (!mram_oe_n) begin oe_cnt++; if (oe_first < 0) oe_first = i; end
            if (mram_dq_oe) begin dqoe_cnt++; if (mram_dq_o !== d) bad_pin++; end
            if (rsp_valid) begin rsp_cnt++; rsp_idx = i; rdata = rsp_rdata; end
            i++;
        end while (!req_ready && i < 40);
        check("ready_returns", 32'(req_ready), 32'd1);
        check("busy_while_occupied", 32'(busy_lo), 32'd1);

        if (be != 2'b00) begin
            check("occupancy", 32'(i), 32'(SETUP + (we ? WRP : RDA) + REC + 1));
            check("ce_low_cycles", 32'(ce_cnt), 32'(SETUP + (we ? WRP : RDA)));
            check("ce_first", 32'(ce_first), 32'd0);
            check("pins_stable", 32'(bad_pin), 32'd0);
            if (we) begin
                check("we_low_cycles", 32'(we_cnt), 32'(WRP));
                check("we_start", 32'(we_first), 32'(SETUP));
                check("wr_oe_low", 32'(oe_cnt), 32'd0);
                check("wr_dq_oe_cycles", 32'(dqoe_cnt), 32'(SETUP + WRP + REC));
                check("wr_rsp_count", 32'(rsp_cnt), 32'd0);
                ref_mem[a] = merge(ref_rd(a), d, be[0], be[1]);
            end else begin
                check("oe_low_cycles", 32'(oe_cnt), 32'(RDA));
                check("oe_start", 32'(oe_first), 32'(SETUP));
                check("rd_we_low", 32'(we_cnt), 32'd0);
                check("rd_dq_oe", 32'(dqoe_cnt), 32'd0);
                check("rd_rsp_count", 32'(rsp_cnt), 32'd1);
                check("rd_rsp_time", 32'(rsp_idx), 32'(SETUP + RDA));
                check("rd_data", 32'(rdata), 32'(exp_rd));
            end
        end else begin
            check("be0_occupancy", 32'(i), 32'd2);
            check("be0_no_ce", 32'(ce_cnt), 32'd0);
            check("be0_no_dq_oe", 32'(dqoe_cnt), 32'd0);
            check("be0_rsp_count", 32'(rsp_cnt), 32'(we ? 0 : 1));
            if (!we) begin
                check("be0_rsp_time", 32'(rsp_idx), 32'd0);
                check("be0_rdata", 32'(rdata), 32'd0);
            end
        end
    endtask

    initial begin
        int n;
        int k;
        ref_mem[20'h00ABC] = 16'h5A3C; dev_mem[20'h00ABC] = 16'h5A3C;
        ref_mem[20'h00F00] = 16'hFFFF; dev_mem[20'h00F00] = 16'hFFFF;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_addr", 32'(mram_addr), 32'd0);
        check("rst_dq_o", 32'(mram_dq_o), 32'd0);
        check("rst_dq_oe", 32'(mram_dq_oe), 32'd0);
        check("rst_strobes_n", 32'({mram_ce_n, mram_we_n, mram_oe_n, mram_lb_n, mram_ub_n}), 32'h1F);
        rst = 1'b0;

        // Directed accesses
        run_req(1'b1, 20'h12345, 16'hBEEF, 2'b11);
        run_req(1'b0, 20'h12345, 16'h0000, 2'b11);
        run_req(1'b0, 20'h00ABC, 16'h0000, 2'b11);
        run_req(1'b0, 20'h00F00, 16'h0000, 2'b01);
        run_req(1'b1, 20'h00F00, 16'h1234, 2'b10);
        run_req(1'b0, 20'h00F00, 16'h0000, 2'b11);

        // Back-to-back with req_valid held high: write 0x00001 then read it back
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 20'h00001; req_wdata = 16'hC0DE; req_be = 2'b11;
        check("b2b_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin req_we = 1'b0; req_wdata = 16'h0000; end
        end while (!req_ready && n < 40);
        check("b2b_gap", 32'(n), 32'(SETUP + WRP + REC + 1));
        ref_mem[20'h00001] = 16'hC0DE;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 40) begin @(negedge clk); k++; end
        check("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
        check("b2b_rsp_time", 32'(k), 32'(SETUP + RDA));
        check("b2b_rdata", 32'(rsp_rdata), 32'(ref_rd(20'h00001)));
        k = 0;
        while (!req_ready && k < 40) begin @(negedge clk); k++; end
        check("b2b_idle", 32'(req_ready), 32'd1);

        // Reset pulsed during WRITE
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 20'h80000; req_wdata = 16'h7777; req_be = 2'b11;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (mram_we_n && k < 20) begin @(negedge clk); k++; end
        check("rst_mid_in_write", 32'(mram_we_n), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_strobes_n", 32'({mram_ce_n, mram_we_n, mram_oe_n, mram_lb_n, mram_ub_n}), 32'h1F);
        check("rst_mid_dq_oe", 32'(mram_dq_oe), 32'd0);
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        check("rst_mid_rsp", 32'(rsp_valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        k = 0;
        repeat (4) begin @(negedge clk); if (rsp_valid) k++; end
        check("rst_mid_no_rsp", 32'(k), 32'd0);
        run_req(1'b0, 20'h00ABC, 16'h0000, 2'b11);

        // Zero byte enables: read answers 0, write is dropped
        run_req(1'b0, 20'h00ABC, 16'h0000, 2'b00);
        run_req(1'b1, 20'h00ABC, 16'h1111, 2'b00);
        run_req(1'b0, 20'h00ABC, 16'h0000, 2'b11);

        // Random traffic over a small address pool
        for (int t = 0; t < 40; t++) begin
            run_req(1'($urandom_range(0, 1)), 20'($urandom_range(0, 7)),
                    16'($urandom), 2'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
